// File: rtl/tdes_job_sequencer_if.sv
// tdes_job_sequencer_if: register-write/FIFO-read bus from the AHB slave controller plus the 3DES core handshake.
// master: slave controller + core side (drives writes, pops, core_done/core_result)
// slave:  the job sequencer (drives FIFO status, busy/err and the core launch signals)
interface tdes_job_sequencer_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [63:0] rd_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        busy;
  logic        err;
  logic        core_start;
  logic        core_encrypt;
  logic [63:0] core_data;
  logic [63:0] core_key1;
  logic [63:0] core_key2;
  logic [63:0] core_key3;
  logic        core_done;
  logic [63:0] core_result;
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, core_done, core_result,
    input  rd_data, fifo_empty, fifo_full, busy, err,
           core_start, core_encrypt, core_data, core_key1, core_key2, core_key3
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, core_done, core_result,
    output rd_data, fifo_empty, fifo_full, busy, err,
           core_start, core_encrypt, core_data, core_key1, core_key2, core_key3
  );
endinterface

// File: rtl/tdes_job_sequencer.sv
// tdes_job_sequencer: holds 3DES key/data registers, launches core jobs with a watchdog, queues results in a FWFT FIFO.
// Ports: HCLK (clock), HRESET (async active-low reset), bus (tdes_job_sequencer_if.slave: register writes,
//        FIFO pops/status, busy/err, core launch/result handshake).
// Optional: define TDES_AUTOSTART_EN to make an idle DATA write also launch a job.
module tdes_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic HCLK,
  input logic HRESET,
  tdes_job_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, STORE, STALL} state_t;
  state_t        state;
  logic [WW-1:0] wd;
  logic [63:0]   result;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0]   cnt;
  logic          wr_ctrl, wr_reg, wr_bad, start_req, timeout, push, pop;

  assign wr_ctrl = bus.wr_en && bus.wr_addr == 3'd0;
  assign wr_reg  = bus.wr_en && bus.wr_addr != 3'd0 && bus.wr_addr <= 3'd4;
  assign wr_bad  = bus.wr_en && bus.wr_addr > 3'd4;
`ifdef TDES_AUTOSTART_EN
  assign start_req = (wr_ctrl && bus.wr_data[1]) || (bus.wr_en && bus.wr_addr == 3'd1);
`else
  assign start_req = wr_ctrl && bus.wr_data[1];
`endif
  assign timeout = state == WAIT && !bus.core_done && wd == WW'(TIMEOUT - 1);
  assign pop = bus.rd_en && cnt != '0;
  assign bus.fifo_empty = cnt == '0;
  assign bus.fifo_full  = cnt == (AW + 1)'(DEPTH);
  // A stalled result may go in on the same edge a pop frees its slot.
  assign push = (state == STORE && !bus.fifo_full) || (state == STALL && (!bus.fifo_full || pop));
  assign bus.busy = state != IDLE;
  assign bus.rd_data = mem[rp];

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state            <= IDLE;
      wd               <= '0;
      result           <= '0;
      bus.err          <= 1'b0;
      bus.core_start   <= 1'b0;
      bus.core_encrypt <= 1'b0;
      bus.core_data    <= '0;
      bus.core_key1    <= '0;
      bus.core_key2    <= '0;
      bus.core_key3    <= '0;
    end else begin
      bus.core_start <= 1'b0;
      if (wr_ctrl && !bus.busy) bus.core_encrypt <= bus.wr_data[0];
      if (wr_reg && !bus.busy && bus.wr_addr == 3'd1) bus.core_data <= bus.wr_data;
      if (wr_reg && !bus.busy && bus.wr_addr == 3'd2) bus.core_key1 <= bus.wr_data;
      if (wr_reg && !bus.busy && bus.wr_addr == 3'd3) bus.core_key2 <= bus.wr_data;
      if (wr_reg && !bus.busy && bus.wr_addr == 3'd4) bus.core_key3 <= bus.wr_data;
      // Any error event in the same cycle as a clear request wins.
      if (wr_bad || (wr_reg && bus.busy) || (start_req && bus.busy) || timeout) bus.err <= 1'b1;
      else if (wr_ctrl && bus.wr_data[2]) bus.err <= 1'b0;
      case (state)
        IDLE: if (start_req) begin
          state          <= LAUNCH;
          bus.core_start <= 1'b1;
        end
        LAUNCH: begin
          wd    <= '0;
          state <= WAIT;
        end
        WAIT: if (bus.core_done) begin
          result <= bus.core_result;
          state  <= STORE;
        end else if (timeout) state <= IDLE;
        else wd <= wd + 1'b1;
        STORE: state <= push ? IDLE : STALL;
        STALL: state <= push ? IDLE : STALL;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= result;
        wp      <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
endmodule

// File: doc/tdes_job_sequencer.md
Name: tdes_job_sequencer

Overview:
- Sits between the AHB-Lite slave controller and the 3DES datapath core inside TopLevel.
- Holds the key and data registers written by the slave controller, launches 3DES jobs on the core, and captures core results.
- Queues results in a small FIFO that the slave controller drains on HRDATA reads.

Parameters:
DEPTH, 4, result FIFO depth in 64-bit entries; power of 2, minimum 2
TIMEOUT, 64, HCLK cycles allowed from core_start to core_done before the job is aborted

Ports:
HCLK  in  1  system clock, all logic on rising edge
HRESET  in  1  asynchronous active-low reset
wr_en  in  1  single-cycle register write strobe from slave controller
wr_addr  in  3  register offset: 0=CTRL, 1=DATA, 2=KEY1, 3=KEY2, 4=KEY3; 5-7 unmapped
wr_data  in  64  write data
rd_en  in  1  pop strobe for result FIFO
rd_data  out  64  FIFO head entry; valid when fifo_empty=0
fifo_empty  out  1  result FIFO empty
fifo_full  out  1  result FIFO full
busy  out  1  job in flight (state != IDLE)
err  out  1  sticky error flag
core_start  out  1  one-cycle launch pulse to core
core_encrypt  out  1  1=encrypt, 0=decrypt; held for the whole job
core_data  out  64  job input block
core_key1  out  64  key 1
core_key2  out  64  key 2
core_key3  out  64  key 3
core_done  in  1  one-cycle completion pulse from core
core_result  in  64  result, valid when core_done=1

Behaviour:
- Reset (HRESET=0, asynchronous): all registers cleared.
  - Outputs: core_start=0, core_encrypt=0, all data/key outputs 0, rd_data=0, fifo_empty=1, fifo_full=0, busy=0, err=0.
  - FSM goes to IDLE; FIFO pointers and count go to 0.
- Register writes:
  - DATA, KEY1, KEY2 and KEY3 load wr_data on the edge where wr_en=1, but only when busy=0.
  - Any of these writes while busy=1 is dropped and sets err.
  - CTRL write: wr_data[0] loads core_encrypt; wr_data[1]=1 requests a job; wr_data[2]=1 clears err.
  - Writes to offsets 5-7 are ignored and set err.
- FSM states: IDLE, LAUNCH, WAIT, STORE, STALL.
  - IDLE -> LAUNCH: CTRL write with start bit set and busy=0.
  - IDLE, start requested while busy=1: ignored, err set.
  - LAUNCH: core_start=1 for exactly one cycle; watchdog counter cleared; -> WAIT.
  - WAIT, core_done=1: capture core_result; -> STORE.
  - WAIT, watchdog reaches TIMEOUT-1 without core_done: set err; -> IDLE; no FIFO push.
  - STORE, FIFO not full: push captured result; -> IDLE.
  - STORE, FIFO full: -> STALL.
  - STALL: hold the captured result; push it on the first cycle the FIFO is not full (including the cycle a simultaneous pop frees a slot); -> IDLE.
  - core_done in any state other than WAIT is ignored.
- Latency: CTRL start write at edge N -> core_start high in cycle N+1. core_done at edge M -> entry visible (fifo_empty=0) after edge M+2, assuming the FIFO is not full.
- FIFO:
  - First-word-fall-through: rd_data always shows the head entry.
  - rd_en while empty: ignored, no pointer change, err not set.
  - Simultaneous push and pop while non-empty: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.
- busy is high in LAUNCH, WAIT, STORE and STALL.
- Reset mid-job discards the job and the FIFO contents; a late core_done after reset is ignored because the FSM is in IDLE.

Optional Feature:
- Macro: TDES_AUTOSTART_EN.
- Defined: a DATA write while busy=0 loads the data and also requests a job, identical to a CTRL start write in the same cycle; core_encrypt keeps its last CTRL value.
- Not defined: jobs start only from the CTRL start bit; DATA writes never launch a job.

Test Plan:
- Reset then idle: HRESET=0 for 2 cycles then release -> all outputs at reset values, fifo_empty=1, busy=0.
- Single job: write KEY1=0x1111111111111111, KEY2=0x2222222222222222, KEY3=0x3333333333333333, DATA=0x0000000000000001, then CTRL=0x3.
  - Required: core_start pulses once one cycle later, with core_encrypt=1 and the written data and key values on the core outputs.
  - Bench model returns core_done with 0x4444444444444444 eight cycles after core_start -> rd_data=0x4444444444444444 and fifo_empty=0 two cycles later.
- FIFO full and stall: with DEPTH=4, run 5 jobs without rd_en -> fifo_full=1 and FSM in STALL with busy=1.
  - Then one rd_en -> fifth result pushed and busy=0.
  - Drain all -> results come out in job order.
- Timeout: start a job, model never asserts core_done -> after 64 cycles err=1, busy=0, fifo_empty unchanged.
  - Then CTRL=0x4 -> err=0.
- Illegal access: write KEY2 during WAIT -> err=1 and core_key2 unchanged; rd_en with FIFO empty -> no change.
- Autostart (compiled with TDES_AUTOSTART_EN): DATA=0x5555555555555555 with busy=0 -> core_start one cycle later without any CTRL write.
  - Without the macro: no core_start is generated.
